estado_mascota: RTL and testbench
=================================

// Module: estado_mascota
// PURPOSE
//  Reads the four 2-bit need levels produced by the Modos block (animo, energia, descanso,
//  medicina) and decides the pet's displayed expression.
//  Generates the activo_comida / activo_medicina enables that Modos consumes.
//  Debounces level changes with a dwell timer, latches death, and supports a test sweep.
//  Sits between Modos and the display driver.
// PARAMETERS
//  MIN_HOLD  50_000_000   cycles a new candidate state must stay stable before adoption (>=1)
//  T_MUERTE  500_000_000  cycles with >=3 levels at 0 before entering MUERTO (>=1)
//  T_TEST    100_000_000  cycles per expression step in test sweep (>=1)
//  UMBRAL    1            level <= UMBRAL counts as an active need (0..2)
// PORTS
//  clk              in   1  system clock
//  reset            in   1  synchronous, active-low reset
//  nivel_animo      in   2  mood level, 0 = critical, 3 = full
//  nivel_energia    in   2  energy level
//  nivel_descanso   in   2  rest level
//  nivel_medicina   in   2  health level
//  senal_test       in   1  test mode active (level)
//  expresion        out  3  0 FELIZ, 1 HAMBRIENTO, 2 ENFERMO, 3 CANSADO, 4 TRISTE, 5 MUERTO
//  activo_comida    out  1  feeding button enabled
//  activo_medicina  out  1  medicine button enabled
//  alarma           out  1  1-cycle pulse on entry into any need state (codes 1..4)
//  muerto           out  1  sticky death flag
// BEHAVIOUR
//  Reset (reset == 0 at a clk edge): state = FELIZ, all counters = 0, muerto = 0, alarma = 0.
//   expresion = 0, activo_comida = 1, activo_medicina = 0.
//   Reset applies at any time, including mid-dwell, mid-test and in MUERTO.
//  Candidate (combinational), first match wins:
//   1. nivel_medicina <= UMBRAL -> ENFERMO
//   2. nivel_energia <= UMBRAL -> HAMBRIENTO
//   3. nivel_descanso <= UMBRAL -> CANSADO
//   4. nivel_animo <= UMBRAL -> TRISTE
//   5. otherwise -> FELIZ
//  Dwell counter:
//   - Clears when candidate == state or when the candidate changes.
//   - Otherwise increments.
//   - When the counter reaches MIN_HOLD-1, state <= candidate on that edge and the counter clears.
//   - Net effect: candidate constant from cycle k gives a new state visible in cycle k+MIN_HOLD.
//   - MIN_HOLD = 1 gives a 1-cycle lag.
//  Death counter:
//   - Increments while at least 3 of the 4 levels == 0; otherwise clears.
//   - On reaching T_MUERTE-1: muerto <= 1, state <= MUERTO, overriding the dwell logic.
//   - MUERTO is absorbing; only reset leaves it.
//  Test mode (senal_test == 1): overrides everything.
//   - expresion steps 0,1,2,3,4,5,0... advancing every T_TEST cycles, starting at 0 in the first test cycle.
//   - Need-state evaluation is frozen: dwell counter cleared, state held.
//   - The death counter keeps running, so muerto may set during test.
//   - alarma is suppressed.
//   - activo_comida = activo_medicina = 1 so both buttons can be exercised.
//   - On senal_test falling: the next cycle shows state (MUERTO if muerto), and the sweep counter clears.
//  Outputs, registered and decoded from state:
//   - expresion = state code.
//   - activo_comida = 0 only in CANSADO and MUERTO.
//   - activo_medicina = 1 only in ENFERMO.
//   - alarma = 1 for exactly one cycle in the first cycle a need state is visible.
//     No pulse on ENFERMO->ENFERMO, on entry to FELIZ or MUERTO, or on leaving test.
//  Simultaneous death timeout and dwell completion on the same edge: MUERTO wins.
//  Counter widths are $clog2(param+1); counters saturate and never wrap.
// STRUCTURE
//  estado_pkg: expression codes (localparams FELIZ..MUERTO) and the 3-bit code width.
//   Shared with the display driver.
//  Sub-module contador_permanencia #(N): clear/enable, saturating counter with done flag.
//   Instantiated three times: dwell, death, test sweep.
//  Top level: candidate mux, state register, output decode.
// TESTING (bench params MIN_HOLD=4, T_MUERTE=16, T_TEST=3)
//  1. Reset, all levels 3 -> expresion=0, activo_comida=1, activo_medicina=0, alarma=0, muerto=0.
//  2. nivel_energia 3->1 at cycle k, held -> expresion=1 at k+4, alarma pulse at k+4 only.
//  3. nivel_energia=1 for 2 cycles then back to 3 -> expresion stays 0, no alarma (dwell aborted).
//  4. medicina=0 and energia=0 together -> ENFERMO chosen; activo_medicina=1 after 4 cycles.
//  5. animo=energia=descanso=0 for 16 cycles -> muerto=1, expresion=5, activo_comida=0.
//     Levels back to 3 -> stays 5 until reset=0.
//  6. senal_test=1 for 18 cycles -> expresion 0,0,0,1,1,1,...,5,5,5 with both enables 1.
//     On release, previous state shown next cycle with no alarma.
//     Repeat with reset=0 pulsed mid-sweep -> FELIZ next cycle.

Source files
------------

// File: rtl/estado_pkg.sv
// Expression codes shared by the pet state logic and the display driver.
package estado_pkg;

  localparam int EXPR_W = 3;

  typedef logic [EXPR_W-1:0] expr_t;

  localparam expr_t FELIZ      = 3'd0;
  localparam expr_t HAMBRIENTO = 3'd1;
  localparam expr_t ENFERMO    = 3'd2;
  localparam expr_t CANSADO    = 3'd3;
  localparam expr_t TRISTE     = 3'd4;
  localparam expr_t MUERTO     = 3'd5;

endpackage

// File: rtl/contador_permanencia.sv
// Dwell counter: counts enabled cycles, pulses done on the N-th one and restarts.
// clr restarts the count within the current cycle; en low clears it.
module contador_permanencia #(
  parameter int N = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(N + 1);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] MAXV = W'(N);

  logic [W-1:0] cnt;
  logic [W-1:0] eff;

  function automatic logic [W-1:0] inc_sat(input logic [W-1:0] v);
    return (v >= MAXV) ? MAXV : v + 1'b1;
  endfunction

  always_comb begin
    eff  = clr ? '0 : cnt;
    done = en && (eff == LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || done) begin
      cnt <= '0;
    end else begin
      cnt <= inc_sat(eff);
    end
  end

endmodule

// File: rtl/estado_mascota.sv
// Pet expression selector: debounced need priority, death latch and test sweep.
// All outputs are registered from the next state so they align with the state change.
module estado_mascota
  import estado_pkg::*;
#(
  parameter int MIN_HOLD = 50_000_000,
  parameter int T_MUERTE = 500_000_000,
  parameter int T_TEST   = 100_000_000,
  parameter int UMBRAL   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] nivel_animo,
  input  logic [1:0] nivel_energia,
  input  logic [1:0] nivel_descanso,
  input  logic [1:0] nivel_medicina,
  input  logic       senal_test,
  output logic [2:0] expresion,
  output logic       activo_comida,
  output logic       activo_medicina,
  output logic       alarma,
  output logic       muerto
);

  localparam logic [1:0] UMB = 2'(UMBRAL);

  expr_t state;
  expr_t state_d;
  expr_t cand;
  expr_t cand_prev;
  expr_t step;
  expr_t step_d;

  logic dwell_en;
  logic dwell_clr;
  logic dwell_done;
  logic death_en;
  logic death_done;
  logic sweep_done;

  function automatic expr_t elegir(input logic [1:0] a, input logic [1:0] e,
                                   input logic [1:0] d, input logic [1:0] m);
    if (m <= UMB) return ENFERMO;
    if (e <= UMB) return HAMBRIENTO;
    if (d <= UMB) return CANSADO;
    if (a <= UMB) return TRISTE;
    return FELIZ;
  endfunction

  function automatic logic tres_ceros(input logic [1:0] a, input logic [1:0] e,
                                      input logic [1:0] d, input logic [1:0] m);
    logic [2:0] n;
    n = {2'b0, a == 2'd0} + {2'b0, e == 2'd0} + {2'b0, d == 2'd0} + {2'b0, m == 2'd0};
    return n >= 3'd3;
  endfunction

  function automatic logic es_necesidad(input expr_t s);
    return (s >= HAMBRIENTO) && (s <= TRISTE);
  endfunction

  always_comb begin
    cand      = elegir(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
    // Evaluation is frozen in test mode and once dead; death still counts in test.
    dwell_en  = !senal_test && !muerto && (cand != state);
    dwell_clr = (cand != cand_prev);
    death_en  = tres_ceros(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
  end

  contador_permanencia #(.N(MIN_HOLD)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (dwell_clr),
    .en    (dwell_en),
    .done  (dwell_done)
  );

  contador_permanencia #(.N(T_MUERTE)) u_death (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (death_en),
    .done  (death_done)
  );

  contador_permanencia #(.N(T_TEST)) u_sweep (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (senal_test),
    .done  (sweep_done)
  );

  // Death overrides a dwell completion on the same edge.
  always_comb begin
    state_d = state;
    if (death_done) begin
      state_d = MUERTO;
    end else if (dwell_done) begin
      state_d = cand;
    end

    step_d = step;
    if (!senal_test) begin
      step_d = FELIZ;
    end else if (sweep_done) begin
      step_d = (step == MUERTO) ? FELIZ : expr_t'(step + 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= FELIZ;
      cand_prev       <= FELIZ;
      step            <= FELIZ;
      muerto          <= 1'b0;
      expresion       <= FELIZ;
      activo_comida   <= 1'b1;
      activo_medicina <= 1'b0;
      alarma          <= 1'b0;
    end else begin
      state     <= state_d;
      cand_prev <= cand;
      step      <= step_d;
      if (death_done) begin
        muerto <= 1'b1;
      end
      if (senal_test) begin
        expresion       <= step;
        activo_comida   <= 1'b1;
        activo_medicina <= 1'b1;
        alarma          <= 1'b0;
      end else begin
        expresion       <= state_d;
        activo_comida   <= !((state_d == CANSADO) || (state_d == MUERTO));
        activo_medicina <= (state_d == ENFERMO);
        alarma          <= (state_d != state) && es_necesidad(state_d);
      end
    end
  end

endmodule

// File: tb/tb_estado_mascota.sv
// Bench for estado_mascota: directed scenarios plus random levels, scoreboarded
// against a cycle-level behavioural model of the pet rules.
module tb_estado_mascota;

  localparam int MIN_HOLD = 4;
  localparam int T_MUERTE = 16;
  localparam int T_TEST   = 3;
  localparam int UMBRAL   = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] nivel_animo = 2'd3;
  logic [1:0] nivel_energia = 2'd3;
  logic [1:0] nivel_descanso = 2'd3;
  logic [1:0] nivel_medicina = 2'd3;
  logic       senal_test = 1'b0;
  logic [2:0] expresion;
  logic       activo_comida;
  logic       activo_medicina;
  logic       alarma;
  logic       muerto;

  estado_mascota #(
    .MIN_HOLD (MIN_HOLD),
    .T_MUERTE (T_MUERTE),
    .T_TEST   (T_TEST),
    .UMBRAL   (UMBRAL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .nivel_animo     (nivel_animo),
    .nivel_energia   (nivel_energia),
    .nivel_descanso  (nivel_descanso),
    .nivel_medicina  (nivel_medicina),
    .senal_test      (senal_test),
    .expresion       (expresion),
    .activo_comida   (activo_comida),
    .activo_medicina (activo_medicina),
    .alarma          (alarma),
    .muerto          (muerto)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0] e;
    logic       c;
    logic       m;
    logic       a;
    logic       d;
  } exp_t;

  exp_t q[$];

  // Reference model: need priority, stability runs and elapsed-time arithmetic.
  int m_state = 0, m_pend = 0, m_pend_cand = 0, m_zero = 0, m_tcnt = 0;
  int m_old, m_cand, m_zeros;
  bit m_dead = 0;
  exp_t m_x;

  function automatic int cand_of(input int a, input int e, input int d, input int m);
    if (m <= UMBRAL) return 2;
    if (e <= UMBRAL) return 1;
    if (d <= UMBRAL) return 3;
    if (a <= UMBRAL) return 4;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0; m_pend = 0; m_zero = 0; m_tcnt = 0; m_dead = 0;
      m_x = '{e: 3'd0, c: 1'b1, m: 1'b0, a: 1'b0, d: 1'b0};
    end else begin
      m_old   = m_state;
      m_cand  = cand_of(int'(nivel_animo), int'(nivel_energia),
                        int'(nivel_descanso), int'(nivel_medicina));
      m_zeros = int'(nivel_animo == 0) + int'(nivel_energia == 0)
              + int'(nivel_descanso == 0) + int'(nivel_medicina == 0);
      if (m_zeros >= 3) m_zero++; else m_zero = 0;
      if (m_zero == T_MUERTE) m_dead = 1;
      if (!senal_test && !m_dead && m_cand != m_state) begin
        if (m_pend > 0 && m_cand == m_pend_cand) m_pend++; else m_pend = 1;
        m_pend_cand = m_cand;
      end else begin
        m_pend = 0;
      end
      if (m_pend == MIN_HOLD) begin
        m_state = m_cand;
        m_pend  = 0;
      end
      if (m_dead) m_state = 5;
      if (senal_test) m_tcnt++; else m_tcnt = 0;
      if (senal_test) begin
        m_x.e = 3'(((m_tcnt - 1) / T_TEST) % 6);
        m_x.c = 1'b1;
        m_x.m = 1'b1;
        m_x.a = 1'b0;
      end else begin
        m_x.e = 3'(m_state);
        m_x.c = !(m_state == 3 || m_state == 5);
        m_x.m = (m_state == 2);
        m_x.a = (m_state != m_old) && (m_state >= 1) && (m_state <= 4);
      end
      m_x.d = m_dead;
    end
    q.push_back(m_x);
  end

  bit done = 0;
  exp_t got;

  always @(posedge clk) begin
    #1;
    if (!done) begin
      if (q.size() == 0) begin
        check("sb_queue_empty", 0, 1);
      end else begin
        got = q.pop_front();
        check("sb_expresion", int'(expresion), int'(got.e));
        check("sb_comida", int'(activo_comida), int'(got.c));
        check("sb_medicina", int'(activo_medicina), int'(got.m));
        check("sb_alarma", int'(alarma), int'(got.a));
        check("sb_muerto", int'(muerto), int'(got.d));
      end
    end
  end

  task automatic set_lv(input int a, input int e, input int d, input int m);
    nivel_animo    = 2'(a);
    nivel_energia  = 2'(e);
    nivel_descanso = 2'(d);
    nivel_medicina = 2'(m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_lv(3, 3, 3, 3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_expresion", int'(expresion), 0);
    check("rst_comida", int'(activo_comida), 1);
    check("rst_medicina", int'(activo_medicina), 0);
    check("rst_alarma", int'(alarma), 0);
    check("rst_muerto", int'(muerto), 0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    // Energy need adopted after MIN_HOLD cycles with a single alarm pulse
    nivel_energia = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    check("hambre_early_expr", int'(expresion), 0);
    check("hambre_early_alarma", int'(alarma), 0);
    @(posedge clk);
    #1;
    check("hambre_expr", int'(expresion), 1);
    check("hambre_alarma", int'(alarma), 1);
    @(posedge clk);
    #1;
    check("hambre_alarma_off", int'(alarma), 0);
    @(negedge clk) nivel_energia = 2'd3;
    repeat (6) @(negedge clk);

    // Aborted dwell
    nivel_energia = 2'd1;
    repeat (2) @(negedge clk);
    nivel_energia = 2'd3;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort_expr", int'(expresion), 0);
      check("abort_alarma", int'(alarma), 0);
    end

    // Medicine has priority over energy
    @(negedge clk) set_lv(3, 0, 3, 0);
    repeat (3) @(posedge clk);
    #1;
    check("enfermo_early", int'(expresion), 0);
    @(posedge clk);
    #1;
    check("enfermo_expr", int'(expresion), 2);
    check("enfermo_medicina", int'(activo_medicina), 1);

    // Death after T_MUERTE cycles with three levels at zero
    @(negedge clk) set_lv(0, 0, 0, 3);
    repeat (15) @(posedge clk);
    #1;
    check("muerte_early", int'(muerto), 0);
    @(posedge clk);
    #1;
    check("muerte_flag", int'(muerto), 1);
    check("muerte_expr", int'(expresion), 5);
    check("muerte_comida", int'(activo_comida), 0);
    @(negedge clk) set_lv(3, 3, 3, 3);
    repeat (10) @(posedge clk);
    #1;
    check("muerte_sticky", int'(expresion), 5);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("muerte_reset_expr", int'(expresion), 0);
    check("muerte_reset_flag", int'(muerto), 0);
    @(negedge clk) reset = 1'b1;

    // Test sweep from HAMBRIENTO
    nivel_energia = 2'd1;
    repeat (6) @(negedge clk);
    senal_test = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      check("sweep_expr", int'(expresion), i / T_TEST);
      check("sweep_comida", int'(activo_comida), 1);
      check("sweep_medicina", int'(activo_medicina), 1);
    end
    @(negedge clk) senal_test = 1'b0;
    @(posedge clk);
    #1;
    check("sweep_exit_expr", int'(expresion), 1);
    check("sweep_exit_alarma", int'(alarma), 0);
    check("sweep_exit_medicina", int'(activo_medicina), 0);

    // Reset pulse mid-sweep
    @(negedge clk) senal_test = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("sweep_rst_expr", int'(expresion), 0);
    check("sweep_rst_medicina", int'(activo_medicina), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("sweep_restart_expr", int'(expresion), 0);
    check("sweep_restart_medicina", int'(activo_medicina), 1);
    @(negedge clk) senal_test = 1'b0;
    set_lv(3, 3, 3, 3);

    // Random levels, test toggles and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        nivel_animo    = ($urandom_range(9) < 4) ? 2'd0 : 2'($urandom_range(3));
        nivel_energia  = ($urandom_range(9) < 4) ? 2'd0 : 2'($urandom_range(3));
        nivel_descanso = ($urandom_range(9) < 4) ? 2'd0 : 2'($urandom_range(3));
        nivel_medicina = ($urandom_range(9) < 4) ? 2'd0 : 2'($urandom_range(3));
      end
      if ($urandom_range(59) == 0) senal_test = ~senal_test;
      reset = ($urandom_range(399) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
